ata_pio_xfer: RTL and testbench
===============================

// Module: ata_pio_xfer
// PURPOSE
//  Device-side engine of the ATA sector buffer: moves whole 512-byte sectors between the
//  buffer's 16-bit ATA port and the ATA device data register via PIO cycles (DIOR-/DIOW-).
//  Started by the disk controller after the command is issued; bus side untouched.
//  Buffer holds 8 sectors (2048 halfwords); buffer port has 1-cycle read latency.
// PARAMETERS
//  T_SETUP  3   clk cycles CS/DA valid before strobe asserts (>=1)
//  T_PULSE  8   clk cycles DIOR-/DIOW- held low (>=2)
//  T_RECOV  6   clk cycles strobe high before next cycle (>=1)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high
//  start        in   1   1-cycle pulse: begin transfer (ignored while busy)
//  dir          in   1   1 = buffer->device (write), 0 = device->buffer (read); sampled at start
//  sec_count    in   3   sectors to move, 0 means 8; sampled at start
//  abort        in   1   stop after current PIO cycle completes
//  busy         out  1   transfer in progress
//  done         out  1   1-cycle pulse at end of transfer or abort
//  aborted      out  1   set with done if ended by abort; cleared at start
//  buf_write    out  1   buffer ATA-port write enable
//  buf_addr     out  11  buffer halfword address (byte address bits [11:1])
//  buf_din      out  16  data to buffer
//  buf_dout     in   16  data from buffer, valid 1 cycle after buf_addr
//  ata_drq      in   1   device DRQ, asynchronous
//  ata_cs0_n    out  1   chip select 0
//  ata_da       out  3   register address, always 3'b000 (data reg) when cs0_n low
//  ata_dior_n   out  1   read strobe
//  ata_diow_n   out  1   write strobe
//  ata_dd_in    in   16  device data bus input
//  ata_dd_out   out  16  device data bus output
//  ata_dd_oe    out  1   drive ata_dd_out onto bus
// BEHAVIOUR
//  Reset: busy=0 done=0 aborted=0 buf_write=0 buf_addr=0 buf_din=0; cs0_n=1 dior_n=1 diow_n=1
//   da=0 dd_out=0 dd_oe=0; state IDLE; counters 0.
//  ata_drq passes a 2-FF synchronizer; FSM uses the synchronized value (2-3 cycle lag).
//  Address = {sec_idx[2:0], word_idx[7:0]}; sec_idx starts at 0, word_idx 0..255 per sector.
//  States:
//   IDLE    : start -> latch dir/count, clear aborted, busy=1, -> WAITDRQ.
//   WAITDRQ : drq_s=1 -> (dir ? BUFRD : SETUP); abort here -> FINISH immediately.
//   BUFRD   : buf_addr presented; next cycle latch buf_dout into dd_out -> SETUP.
//   SETUP   : cs0_n=0, dd_oe=dir; T_SETUP cycles -> STROBE.
//   STROBE  : dior_n=0 (read) / diow_n=0 (write) for T_PULSE cycles; read captures
//             ata_dd_in into buf_din on last STROBE cycle -> RECOV.
//   RECOV   : strobes high, cs0_n=0 held, dd_oe held T_RECOV cycles; read: buf_write=1 on
//             first RECOV cycle. End: word_idx++ (wrap 255->0 increments sec_idx).
//             abort latched -> FINISH; last word of last sector -> FINISH;
//             word_idx wrapped -> WAITDRQ (new DRQ per sector); else dir ? BUFRD : SETUP.
//   FINISH  : cs0_n=1, dd_oe=0, busy=0, done=1 one cycle, aborted=abort_latched -> IDLE.
//  abort is latched (sticky until FINISH); never truncates a strobe mid-pulse.
//  start while busy: ignored. start and abort same cycle in IDLE: start wins, abort dropped.
//  sec_count=0 -> 8 sectors, final buf_addr 11'h7FF, no address wrap beyond.
//  dd_oe never 1 while dir=0; dior_n and diow_n never low simultaneously.
//  Reset mid-transfer: all outputs to reset values immediately (async), strobes released.
//  Per-word time: write 1+1+T_SETUP+T_PULSE+T_RECOV cycles, read T_SETUP+T_PULSE+T_RECOV.
// STRUCTURE
//  Constants (state encodings, ATA_REG_DATA=3'b000) in shared include ata_defs.v.
//  One sub-module: ata_pio_cycle -- given go/dir/data runs SETUP/STROBE/RECOV timing,
//   drives cs0_n/strobes/dd_oe, returns captured read data and cycle_done pulse.
//  Top holds FSM, synchronizer, word/sector counters, abort latch, buffer interface.
// TESTING
//  Read 1 sector, drq=1, device model returns word n = 16'hA500+n -> 256 buf_write pulses,
//   addr 0..255, buf_din matches, done once, aborted=0.
//  Write sec_count=0 with buffer preloaded addr-pattern -> 2048 diow_n pulses, device sees
//   words 0..2047 in order, last buf_addr 11'h7FF, dd_oe high only inside cycles.
//  Read 2 sectors, drq drops after sector 0 for 100 cycles -> FSM stalls in WAITDRQ, sector 1
//   starts at addr 11'h100 after drq returns; no strobe during stall.
//  Abort during STROBE of word 10 -> pulse completes full T_PULSE, word 10 written, done with
//   aborted=1, no word 11 cycle.
//  Async reset during STROBE -> dior_n=1, cs0_n=1, busy=0 same edge; next start runs clean.
//  Timing check: measured setup/pulse/recovery equal T_SETUP/T_PULSE/T_RECOV exactly for
//   default and (1,2,1) parameter sets.

Source files
------------

// File: rtl/ata_pio_xfer_pkg.sv
// Shared constants and state encodings for the ATA PIO sector transfer engine.
package ata_pio_xfer_pkg;

  localparam logic [2:0] ATA_REG_DATA = 3'b000;
  localparam int         CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITDRQ,
    ST_BUFRD,
    ST_BUFLAT,
    ST_CYCLE,
    ST_FINISH
  } xfer_state_e;

  typedef enum logic [1:0] {
    CY_IDLE,
    CY_SETUP,
    CY_STROBE,
    CY_RECOV
  } cyc_state_e;

  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/ata_pio_xfer_cycle.sv
// One ATA PIO data-register cycle: SETUP / STROBE / RECOV timing with registered pin outputs.
module ata_pio_cycle
  import ata_pio_xfer_pkg::*;
#(
  parameter int T_SETUP = 3,
  parameter int T_PULSE = 8,
  parameter int T_RECOV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        dir,
  input  logic [15:0] ata_dd_in,
  output logic        cs0_n,
  output logic        dior_n,
  output logic        diow_n,
  output logic        dd_oe,
  output logic [15:0] rdata,
  output logic        rd_capture,
  output logic        cycle_done
);

  cyc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs0_n_q, cs0_n_d;
  logic             dior_n_q, dior_n_d;
  logic             diow_n_q, diow_n_d;
  logic             dd_oe_q, dd_oe_d;
  logic [15:0]      rdata_q, rdata_d;

  assign rd_capture = (state_q == CY_STROBE) && (cnt_q == cnt_last(T_PULSE)) && !dir;
  assign cycle_done = (state_q == CY_RECOV) && (cnt_q == cnt_last(T_RECOV));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CY_IDLE: begin
        if (go) begin
          state_d = CY_SETUP;
          cnt_d   = '0;
        end
      end
      CY_SETUP: begin
        if (cnt_q == cnt_last(T_SETUP)) begin
          state_d = CY_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CY_STROBE: begin
        if (cnt_q == cnt_last(T_PULSE)) begin
          state_d = CY_RECOV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CY_RECOV: begin
        if (cnt_q == cnt_last(T_RECOV)) begin
          state_d = go ? CY_SETUP : CY_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = CY_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pins decode the next state so they change on the same edge as the state, glitch-free
  always_comb begin
    cs0_n_d  = (state_d == CY_IDLE);
    dior_n_d = !((state_d == CY_STROBE) && !dir);
    diow_n_d = !((state_d == CY_STROBE) && dir);
    dd_oe_d  = dir && (state_d != CY_IDLE);
    rdata_d  = rd_capture ? ata_dd_in : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs0_n_q  <= 1'b1;
      dior_n_q <= 1'b1;
      diow_n_q <= 1'b1;
      dd_oe_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cs0_n_q  <= cs0_n_d;
      dior_n_q <= dior_n_d;
      diow_n_q <= diow_n_d;
      dd_oe_q  <= dd_oe_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cs0_n  = cs0_n_q;
  assign dior_n = dior_n_q;
  assign diow_n = diow_n_q;
  assign dd_oe  = dd_oe_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/ata_pio_xfer.sv
// Device-side ATA PIO engine: moves whole sectors between the sector buffer and the
// ATA data register, one DRQ handshake per sector.
module ata_pio_xfer
  import ata_pio_xfer_pkg::*;
#(
  parameter int T_SETUP = 3,
  parameter int T_PULSE = 8,
  parameter int T_RECOV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [2:0]  sec_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        buf_write,
  output logic [10:0] buf_addr,
  output logic [15:0] buf_din,
  input  logic [15:0] buf_dout,
  input  logic        ata_drq,
  output logic        ata_cs0_n,
  output logic [2:0]  ata_da,
  output logic        ata_dior_n,
  output logic        ata_diow_n,
  input  logic [15:0] ata_dd_in,
  output logic [15:0] ata_dd_out,
  output logic        ata_dd_oe
);

  xfer_state_e state_q, state_d;
  logic        go;
  logic        drq_s1_q, drq_s2_q;
  logic        dir_q, dir_d;
  logic [2:0]  last_sec_q, last_sec_d;
  logic [2:0]  sec_q, sec_d;
  logic [7:0]  word_q, word_d;
  logic        abort_q, abort_d;
  logic [15:0] dd_out_q, dd_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        buf_write_q, buf_write_d;
  logic        abort_any, last_word, in_xfer;
  logic        rd_capture, cycle_done;

  assign abort_any = abort_q || abort;
  assign last_word = (sec_q == last_sec_q) && (word_q == 8'hFF);
  assign in_xfer   = (state_q == ST_WAITDRQ) || (state_q == ST_BUFRD) ||
                     (state_q == ST_BUFLAT)  || (state_q == ST_CYCLE);

  ata_pio_cycle #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_RECOV (T_RECOV)
  ) u_cycle (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .dir        (dir_q),
    .ata_dd_in  (ata_dd_in),
    .cs0_n      (ata_cs0_n),
    .dior_n     (ata_dior_n),
    .diow_n     (ata_diow_n),
    .dd_oe      (ata_dd_oe),
    .rdata      (buf_din),
    .rd_capture (rd_capture),
    .cycle_done (cycle_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // go is raised on the cycle that hands the next word to the PIO sequencer
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAITDRQ;
      end
      ST_WAITDRQ: begin
        if (abort_any) begin
          state_d = ST_FINISH;
        end else if (drq_s2_q) begin
          if (dir_q) begin
            state_d = ST_BUFRD;
          end else begin
            state_d = ST_CYCLE;
            go      = 1'b1;
          end
        end
      end
      ST_BUFRD:  state_d = ST_BUFLAT;
      ST_BUFLAT: begin
        state_d = ST_CYCLE;
        go      = 1'b1;
      end
      ST_CYCLE: begin
        if (cycle_done) begin
          if (abort_any || last_word) state_d = ST_FINISH;
          else if (word_q == 8'hFF)   state_d = ST_WAITDRQ;
          else if (dir_q)             state_d = ST_BUFRD;
          else                        go      = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d == ST_WAITDRQ) || (state_d == ST_BUFRD) ||
                  (state_d == ST_BUFLAT)  || (state_d == ST_CYCLE);
    done_d      = (state_d == ST_FINISH);
    buf_write_d = rd_capture;
    aborted_d   = aborted_q;
    if ((state_q == ST_IDLE) && start)
      aborted_d = 1'b0;
    else if ((state_d == ST_FINISH) && (state_q != ST_FINISH))
      aborted_d = abort_any;
  end

  // Counters stop on the final word so the last address stays visible after the transfer
  always_comb begin
    dir_d      = dir_q;
    last_sec_d = last_sec_q;
    sec_d      = sec_q;
    word_d     = word_q;
    abort_d    = in_xfer && abort_any;
    dd_out_d   = (state_q == ST_BUFLAT) ? buf_dout : dd_out_q;
    if ((state_q == ST_IDLE) && start) begin
      dir_d      = dir;
      last_sec_d = sec_count - 3'd1;
      sec_d      = '0;
      word_d     = '0;
    end else if ((state_q == ST_CYCLE) && cycle_done && !last_word) begin
      word_d = word_q + 8'd1;
      if (word_q == 8'hFF) sec_d = sec_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drq_s1_q    <= 1'b0;
      drq_s2_q    <= 1'b0;
      dir_q       <= 1'b0;
      last_sec_q  <= '0;
      sec_q       <= '0;
      word_q      <= '0;
      abort_q     <= 1'b0;
      dd_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      buf_write_q <= 1'b0;
    end else begin
      drq_s1_q    <= ata_drq;
      drq_s2_q    <= drq_s1_q;
      dir_q       <= dir_d;
      last_sec_q  <= last_sec_d;
      sec_q       <= sec_d;
      word_q      <= word_d;
      abort_q     <= abort_d;
      dd_out_q    <= dd_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      buf_write_q <= buf_write_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign buf_write  = buf_write_q;
  assign buf_addr   = {sec_q, word_q};
  assign ata_da     = ATA_REG_DATA;
  assign ata_dd_out = dd_out_q;

endmodule

// File: tb/tb_ata_pio_xfer.sv
// Directed bench for ata_pio_xfer: sector buffer and ATA device models, pin-timing monitor.
module tb_ata_pio_xfer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, f_start, dir, abort, ata_drq;
  logic [2:0]  sec_count;
  logic        busy, done, aborted, buf_write;
  logic [10:0] buf_addr;
  logic [15:0] buf_din, buf_dout, ata_dd_in, ata_dd_out;
  logic        ata_cs0_n, ata_dior_n, ata_diow_n, ata_dd_oe;
  logic [2:0]  ata_da;

  logic        f_busy, f_done, f_aborted, f_buf_write;
  logic [10:0] f_buf_addr;
  logic [15:0] f_buf_din, f_buf_dout, f_dd_out;
  logic        f_cs0_n, f_dior_n, f_diow_n, f_dd_oe;
  logic [2:0]  f_da;

  ata_pio_xfer dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .sec_count(sec_count),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .buf_write(buf_write), .buf_addr(buf_addr), .buf_din(buf_din), .buf_dout(buf_dout),
    .ata_drq(ata_drq), .ata_cs0_n(ata_cs0_n), .ata_da(ata_da),
    .ata_dior_n(ata_dior_n), .ata_diow_n(ata_diow_n), .ata_dd_in(ata_dd_in),
    .ata_dd_out(ata_dd_out), .ata_dd_oe(ata_dd_oe)
  );

  ata_pio_xfer #(.T_SETUP(1), .T_PULSE(2), .T_RECOV(1)) dut_f (
    .clk(clk), .reset(reset), .start(f_start), .dir(dir), .sec_count(sec_count),
    .abort(abort), .busy(f_busy), .done(f_done), .aborted(f_aborted),
    .buf_write(f_buf_write), .buf_addr(f_buf_addr), .buf_din(f_buf_din), .buf_dout(f_buf_dout),
    .ata_drq(ata_drq), .ata_cs0_n(f_cs0_n), .ata_da(f_da),
    .ata_dior_n(f_dior_n), .ata_diow_n(f_diow_n), .ata_dd_in(ata_dd_in),
    .ata_dd_out(f_dd_out), .ata_dd_oe(f_dd_oe)
  );

  // Pin probes select which instance the timing monitor watches
  logic        sel;
  logic        p_cs0_n, p_dior_n, p_diow_n, p_dd_oe, p_done;
  logic [15:0] p_dd_out;
  assign p_cs0_n  = sel ? f_cs0_n  : ata_cs0_n;
  assign p_dior_n = sel ? f_dior_n : ata_dior_n;
  assign p_diow_n = sel ? f_diow_n : ata_diow_n;
  assign p_dd_oe  = sel ? f_dd_oe  : ata_dd_oe;
  assign p_done   = sel ? f_done   : done;
  assign p_dd_out = sel ? f_dd_out : ata_dd_out;

  // Sector buffer model: 1-cycle read latency, optional address-pattern preload
  logic [15:0] mem [0:2047];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h3C00 ^ 16'(i);
    end else if (buf_write) begin
      mem[buf_addr] <= buf_din;
    end
    buf_dout   <= mem[buf_addr];
    f_buf_dout <= mem[f_buf_addr];
  end

  // Device model and pin monitor
  int   dev_rd, dev_wr, wr_bad, rd_falls, wr_falls, done_cnt, viol, stall_strobes;
  int   bw_cnt, bw_bad, cyc, last_fall, meas_period, meas_setup, meas_pulse, meas_recov;
  int   hi_run, pulse_run, clr_gen, clr_seen;
  logic [10:0] s1_addr;
  logic stall, mon_strb, strb_prev, cs_prev, dior_prev, first_in_burst;

  assign ata_dd_in = 16'hA500 + 16'(dev_rd);

  initial begin
    dev_rd = 0; dev_wr = 0; wr_bad = 0; rd_falls = 0; wr_falls = 0; done_cnt = 0;
    viol = 0; stall_strobes = 0; bw_cnt = 0; bw_bad = 0; cyc = 0; last_fall = 0;
    meas_period = 0; meas_setup = 0; meas_pulse = 0; meas_recov = 0; hi_run = 0;
    pulse_run = 0; clr_seen = 0; s1_addr = '0; strb_prev = 1'b0; cs_prev = 1'b1;
    dior_prev = 1'b1; first_in_burst = 1'b1;
  end

  always @(negedge clk) begin
    cyc++;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      dev_rd = 0; dev_wr = 0; wr_bad = 0; rd_falls = 0; wr_falls = 0; done_cnt = 0;
      viol = 0; stall_strobes = 0; bw_cnt = 0; bw_bad = 0;
    end
    mon_strb = !p_dior_n || !p_diow_n;
    if (p_done) done_cnt++;
    if (!p_dior_n && !p_diow_n) viol++;
    if (p_dd_oe && (!dir || p_cs0_n)) viol++;
    if (mon_strb && stall) stall_strobes++;
    if (p_cs0_n) begin
      if (!cs_prev) meas_recov = hi_run;
      hi_run = 0;
      first_in_burst = 1'b1;
    end
    if (mon_strb && !strb_prev) begin
      if (first_in_burst) meas_setup = hi_run;
      first_in_burst = 1'b0;
      meas_period = cyc - last_fall;
      last_fall = cyc;
      if (!p_dior_n) rd_falls++;
      else           wr_falls++;
      pulse_run = 0;
    end
    if (mon_strb) pulse_run++;
    if (!mon_strb && strb_prev) begin
      meas_pulse = pulse_run;
      hi_run = 0;
      if (!dior_prev) begin
        dev_rd++;
      end else begin
        if (p_dd_out !== (16'h3C00 ^ 16'(dev_wr))) wr_bad++;
        dev_wr++;
      end
    end
    if (!mon_strb && !p_cs0_n) hi_run++;
    if (buf_write) begin
      if (buf_addr !== 11'(bw_cnt) || buf_din !== (16'hA500 + 16'(bw_cnt))) bw_bad++;
      if (bw_cnt == 256) s1_addr = buf_addr;
      bw_cnt++;
    end
    strb_prev = mon_strb;
    cs_prev   = p_cs0_n;
    dior_prev = p_dior_n;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    clr_gen++;
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input logic fast, input logic with_abort);
    @(negedge clk); #1;
    if (fast) f_start = 1'b1; else start = 1'b1;
    abort = with_abort;
    @(negedge clk); #1;
    start = 1'b0; f_start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk); #1;
      if (p_done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; f_start = 1'b0; dir = 1'b0; abort = 1'b0;
    ata_drq = 1'b0; sec_count = 3'd1; stall = 1'b0; preload = 1'b0; sel = 1'b0;
    clr_gen = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_buf_write", 32'(buf_write), 32'd0);
    chk("rst_buf_addr", 32'(buf_addr), 32'd0);
    chk("rst_buf_din", 32'(buf_din), 32'd0);
    chk("rst_pins", {28'd0, ata_cs0_n, ata_dior_n, ata_diow_n, ata_dd_oe}, 32'hE);
    chk("rst_da_dd", {13'd0, ata_da, ata_dd_out}, 32'd0);
    reset = 1'b0;

    // Read one sector, with a stray start while busy
    ata_drq = 1'b1; dir = 1'b0; sec_count = 3'd1;
    clear_stats();
    pulse_start(1'b0, 1'b0);
    chk("rd1_busy", 32'(busy), 32'd1);
    repeat (500) @(negedge clk);
    pulse_start(1'b0, 1'b0);
    wait_done("rd1", 6000);
    repeat (50) @(negedge clk);
    #1;
    chk("rd1_writes", 32'(bw_cnt), 32'd256);
    chk("rd1_data_bad", 32'(bw_bad), 32'd0);
    chk("rd1_done_cnt", 32'(done_cnt), 32'd1);
    chk("rd1_aborted", 32'(aborted), 32'd0);
    chk("rd1_busy_end", 32'(busy), 32'd0);
    chk("rd1_mem255", 32'(mem[255]), 32'hA5FF);
    chk("rd1_setup", 32'(meas_setup), 32'd3);
    chk("rd1_pulse", 32'(meas_pulse), 32'd8);
    chk("rd1_recov", 32'(meas_recov), 32'd6);
    chk("rd1_period", 32'(meas_period), 32'd17);
    chk("rd1_viol", 32'(viol), 32'd0);

    // Write eight sectors from an address-pattern buffer
    dir = 1'b1; sec_count = 3'd0;
    @(negedge clk); #1; preload = 1'b1;
    @(negedge clk); #1; preload = 1'b0;
    clear_stats();
    pulse_start(1'b0, 1'b0);
    wait_done("wr8", 45000);
    chk("wr8_strobes", 32'(wr_falls), 32'd2048);
    chk("wr8_dev_words", 32'(dev_wr), 32'd2048);
    chk("wr8_data_bad", 32'(wr_bad), 32'd0);
    chk("wr8_no_reads", 32'(rd_falls), 32'd0);
    chk("wr8_last_addr", 32'(buf_addr), 32'h7FF);
    chk("wr8_period", 32'(meas_period), 32'd19);
    chk("wr8_viol", 32'(viol), 32'd0);
    chk("wr8_oe_off", 32'(ata_dd_oe), 32'd0);
    dir = 1'b0;

    // Read two sectors with DRQ withdrawn between them
    sec_count = 3'd2;
    clear_stats();
    pulse_start(1'b0, 1'b0);
    for (int n = 0; n < 6000; n++) begin
      if (bw_cnt >= 256) break;
      @(negedge clk); #1;
    end
    ata_drq = 1'b0; stall = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_cs_idle", 32'(ata_cs0_n), 32'd1);
    repeat (50) @(negedge clk);
    #1;
    chk("stall_writes", 32'(bw_cnt), 32'd256);
    ata_drq = 1'b1; stall = 1'b0;
    wait_done("rd2", 6000);
    chk("rd2_writes", 32'(bw_cnt), 32'd512);
    chk("rd2_data_bad", 32'(bw_bad), 32'd0);
    chk("rd2_sec1_addr", 32'(s1_addr), 32'h100);
    chk("rd2_stall_strobes", 32'(stall_strobes), 32'd0);
    chk("rd2_done_cnt", 32'(done_cnt), 32'd1);

    // Abort during the strobe of word 10
    sec_count = 3'd1;
    clear_stats();
    pulse_start(1'b0, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      if (rd_falls >= 11) break;
      @(negedge clk); #1;
    end
    chk("abt_in_strobe", 32'(ata_dior_n), 32'd0);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    wait_done("abt", 200);
    repeat (40) @(negedge clk);
    #1;
    chk("abt_aborted", 32'(aborted), 32'd1);
    chk("abt_writes", 32'(bw_cnt), 32'd11);
    chk("abt_strobes", 32'(rd_falls), 32'd11);
    chk("abt_word10", 32'(mem[10]), 32'hA50A);
    chk("abt_pulse", 32'(meas_pulse), 32'd8);
    chk("abt_recov", 32'(meas_recov), 32'd6);
    chk("abt_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset during a strobe, then start+abort together in IDLE
    clear_stats();
    pulse_start(1'b0, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      if (rd_falls >= 3) break;
      @(negedge clk); #1;
    end
    #1;
    reset = 1'b1;
    #1;
    chk("arst_dior", 32'(ata_dior_n), 32'd1);
    chk("arst_cs", 32'(ata_cs0_n), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(buf_addr), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    clear_stats();
    pulse_start(1'b0, 1'b1);
    wait_done("post_rst", 6000);
    chk("post_rst_aborted", 32'(aborted), 32'd0);
    chk("post_rst_writes", 32'(bw_cnt), 32'd256);
    chk("post_rst_data_bad", 32'(bw_bad), 32'd0);
    chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);

    // Minimum timing parameter set (1,2,1)
    sel = 1'b1;
    clear_stats();
    pulse_start(1'b1, 1'b0);
    wait_done("fast", 2000);
    chk("fast_setup", 32'(meas_setup), 32'd1);
    chk("fast_pulse", 32'(meas_pulse), 32'd2);
    chk("fast_recov", 32'(meas_recov), 32'd1);
    chk("fast_period", 32'(meas_period), 32'd4);
    chk("fast_strobes", 32'(rd_falls), 32'd256);
    chk("fast_last", {5'd0, f_buf_addr, f_buf_din}, {5'd0, 11'h0FF, 16'hA5FF});
    chk("fast_idle", {28'd0, f_busy, f_aborted, f_buf_write, f_dd_oe}, 32'd0);
    chk("fast_da", 32'(f_da), 32'd0);
    chk("fast_viol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
